// File: rtl/mips_dbg_pkg.sv
// Shared types and width helpers for the MIPS run-control / trace monitor.
// The widths are helper functions because they depend on each instance's parameters.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } dbg_state_t;

  // A trace record is {pc, instr, alu, wd, we}, with pc in the most significant field.
  function automatic int tr_width(input int data_w);
    return 4 * data_w + 1;
  endfunction

  function automatic int tr_pc_lsb(input int data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Circular trace FIFO: when full, a push overwrites the oldest entry and sets a sticky overflow flag.
// Reads are registered, and a bypass covers the case where the new head is the entry being written.
module dbg_trace_fifo
  import mips_dbg_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop || (push && full)) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && full && !do_pop) ovf_d = 1'b1;
    if (push && !do_pop && !full) count_d = count_q + CNT_W'(1);
    else if (do_pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  // The registered head must see this cycle's write when it lands on the new read slot.
  always_ff @(posedge clk) begin
    if (srst) rd_data_q <= '0;
    else if (push && (wr_ptr_q == rd_ptr_d)) rd_data_q <= push_data;
    else rd_data_q <= mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/mips_debug_monitor.sv
// Run-control and trace unit for the pipelined MIPS core: PC breakpoints, halt/step/resume
// through a core enable, a circular trace buffer and a count of cycles in which the core ran.
module mips_debug_monitor
  import mips_dbg_pkg::*;
#(
  parameter int NUM_BP       = 4,
  parameter int TRACE_DEPTH  = 16,
  parameter int DATA_W       = 32,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_W-1:0]                  pc_current,
  input  logic [DATA_W-1:0]                  instr,
  input  logic [DATA_W-1:0]                  alu_out,
  input  logic [DATA_W-1:0]                  wd_dm,
  input  logic                               we_dm,
  input  logic                               halt_req,
  input  logic                               step_req,
  input  logic                               resume_req,
  input  logic                               bp_we,
  input  logic [idx_width(NUM_BP)-1:0]       bp_idx,
  input  logic [DATA_W-1:0]                  bp_addr,
  input  logic                               bp_en,
  input  logic                               trace_en,
  input  logic                               tr_ready,
  output logic                               tr_valid,
  output logic [tr_width(DATA_W)-1:0]        tr_data,
  output logic [cnt_width(TRACE_DEPTH)-1:0]  tr_count,
  output logic                               tr_ovf,
  output logic                               cpu_run,
  output logic                               halted,
  output logic                               bp_hit,
  output logic [idx_width(NUM_BP)-1:0]       hit_idx,
  output logic [31:0]                        run_cycles
);
  localparam int IDX_W = idx_width(NUM_BP);
  localparam int TR_W  = tr_width(DATA_W);
  localparam int CNT_W = cnt_width(TRACE_DEPTH);
  localparam dbg_state_t RESET_STATE = START_HALTED ? HALT : RUN;

  dbg_state_t       state_q, state_d;
  logic             bp_hit_q, bp_hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d, first_idx;
  logic             skip_q, skip_d;
  logic [31:0]      run_cycles_q, run_cycles_d;
  logic [NUM_BP-1:0] match;
  logic             any_match;
  logic             trace_push;
  logic [TR_W-1:0]  trace_rec;

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;

    always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      if (bp_we && (bp_idx == IDX_W'(gi))) begin
        addr_d = bp_addr;
        en_d   = bp_en;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        addr_q <= '0;
        en_q   <= 1'b0;
      end else begin
        addr_q <= addr_d;
        en_q   <= en_d;
      end
    end

    assign match[gi] = en_q && (addr_q == pc_current);
  end

  always_comb begin
    first_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (match[i]) first_idx = IDX_W'(i);
    end
  end

  // skip masks the breakpoint at the PC the core was frozen on, so resume/step can move past it.
  assign any_match = (|match) && !skip_q;

  always_comb begin
    state_d   = state_q;
    bp_hit_d  = bp_hit_q;
    hit_idx_d = hit_idx_q;
    skip_d    = skip_q;
    cpu_run   = 1'b0;
    unique case (state_q)
      RUN: begin
        cpu_run = !any_match && !halt_req;
        if (any_match) begin
          state_d   = HALT;
          bp_hit_d  = 1'b1;
          hit_idx_d = first_idx;
        end else if (halt_req) begin
          state_d  = HALT;
          bp_hit_d = 1'b0;
        end
      end
      HALT: begin
        if (step_req) begin
          state_d = STEP;
          skip_d  = 1'b1;
        end else if (resume_req) begin
          state_d = RUN;
          skip_d  = 1'b1;
        end
      end
      STEP: begin
        cpu_run  = 1'b1;
        state_d  = HALT;
        bp_hit_d = 1'b0;
      end
      default: state_d = RESET_STATE;
    endcase
    if (cpu_run) skip_d = 1'b0;
    run_cycles_d = cpu_run ? run_cycles_q + 32'd1 : run_cycles_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      bp_hit_q     <= 1'b0;
      hit_idx_q    <= '0;
      skip_q       <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      bp_hit_q     <= bp_hit_d;
      hit_idx_q    <= hit_idx_d;
      skip_q       <= skip_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign trace_push = cpu_run && trace_en;
  assign trace_rec  = {pc_current, instr, alu_out, wd_dm, we_dm};

  dbg_trace_fifo #(
    .WIDTH (TR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .srst      (rst),
    .push      (trace_push),
    .push_data (trace_rec),
    .pop       (tr_ready),
    .rd_valid  (tr_valid),
    .rd_data   (tr_data),
    .count     (tr_count),
    .ovf       (tr_ovf)
  );

  assign halted     = (state_q == HALT);
  assign bp_hit     = bp_hit_q;
  assign hit_idx    = hit_idx_q;
  assign run_cycles = run_cycles_q;

endmodule
